// File: rtl/nmcu_cache_dm.sv
// Direct-mapped, write-through, no-write-allocate cache between the Control Unit and memory.
// One outstanding request at a time, with a runtime bypass, a single-cycle flush and saturating read hit/miss counters.
module nmcu_cache_dm #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LINES  = 64
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cache_en,
  input  logic              i_flush,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_wdata,
  output logic              o_resp_valid,
  output logic [DATA_W-1:0] o_resp_rdata,
  output logic              o_mem_req_valid,
  input  logic              i_mem_req_ready,
  output logic              o_mem_req_we,
  output logic [ADDR_W-1:0] o_mem_req_addr,
  output logic [DATA_W-1:0] o_mem_req_wdata,
  input  logic              i_mem_resp_valid,
  input  logic [DATA_W-1:0] i_mem_resp_rdata,
  output logic [31:0]       o_hit_cnt,
  output logic [31:0]       o_miss_cnt
);

  localparam int unsigned IDX_W = $clog2(LINES);
  localparam int unsigned TAG_W = ADDR_W - IDX_W;
  localparam int unsigned CNT_W = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MREQ  = 2'd1,
    S_MWAIT = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t            r_state;
  logic [LINES-1:0]  r_valid;
  logic [TAG_W-1:0]  r_tag  [LINES];
  logic [DATA_W-1:0] r_data [LINES];
  logic              r_cached;

  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic [IDX_W-1:0]  w_lidx;
  logic [TAG_W-1:0]  w_ltag;
  logic              w_hit;
  logic              w_accept;
  logic              w_fill;
  logic              w_wr_upd;

  // Incoming request decode, plus the latched request reused for line fills
  assign w_idx    = i_req_addr[IDX_W-1:0];
  assign w_tag    = i_req_addr[ADDR_W-1:IDX_W];
  assign w_lidx   = o_mem_req_addr[IDX_W-1:0];
  assign w_ltag   = o_mem_req_addr[ADDR_W-1:IDX_W];
  assign w_hit    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_accept = (r_state == S_IDLE) && !i_flush && i_req_valid;
  assign w_fill   = (r_state == S_MWAIT) && i_mem_resp_valid && r_cached;
  assign w_wr_upd = w_accept && i_req_we && i_cache_en && w_hit;

  // Flush blocks acceptance combinationally in the cycle it is raised
  assign o_req_ready = (r_state == S_IDLE) && !i_flush;

  // Tag/data arrays need no reset: a line is only trusted when its valid bit is set
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      if (w_wr_upd) begin
        r_data[w_idx] <= i_req_wdata;
      end else if (w_fill) begin
        r_data[w_lidx] <= i_mem_resp_rdata;
        r_tag[w_lidx]  <= w_ltag;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state         <= S_IDLE;
      r_valid         <= '0;
      r_cached        <= 1'b0;
      o_resp_valid    <= 1'b0;
      o_resp_rdata    <= '0;
      o_mem_req_valid <= 1'b0;
      o_mem_req_we    <= 1'b0;
      o_mem_req_addr  <= '0;
      o_mem_req_wdata <= '0;
      o_hit_cnt       <= '0;
      o_miss_cnt      <= '0;
    end else begin
      o_resp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_flush) begin
            r_valid <= '0;
          end else if (i_req_valid) begin
            o_mem_req_we    <= i_req_we;
            o_mem_req_addr  <= i_req_addr;
            o_mem_req_wdata <= i_req_wdata;
            r_cached        <= i_cache_en;
            if (!i_req_we && i_cache_en && w_hit) begin
              o_resp_valid <= 1'b1;
              o_resp_rdata <= r_data[w_idx];
              if (o_hit_cnt != '1) o_hit_cnt <= o_hit_cnt + CNT_W'(1);
              r_state <= S_RESP;
            end else begin
              o_mem_req_valid <= 1'b1;
              if (!i_req_we && i_cache_en && (o_miss_cnt != '1)) begin
                o_miss_cnt <= o_miss_cnt + CNT_W'(1);
              end
              r_state <= S_MREQ;
            end
          end
        end
        S_MREQ: begin
          if (i_mem_req_ready) begin
            o_mem_req_valid <= 1'b0;
            if (o_mem_req_we) begin
              o_resp_valid <= 1'b1;
              o_resp_rdata <= '0;
              r_state      <= S_RESP;
            end else begin
              r_state <= S_MWAIT;
            end
          end
        end
        S_MWAIT: begin
          if (i_mem_resp_valid) begin
            o_resp_valid <= 1'b1;
            o_resp_rdata <= i_mem_resp_rdata;
            if (r_cached) r_valid[w_lidx] <= 1'b1;
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          o_resp_rdata <= '0;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/nmcu_cache_dm.md
# nmcu_cache_dm

Parametrised direct-mapped, write-through, no-write-allocate cache between the Control Unit (sole master) and the memory interface. It replaces the pass-through cache stage with real hit/miss handling. It adds a valid/ready handshake on both sides, a runtime bypass mode, a single-cycle flush, and saturating hit/miss counters. One outstanding request at a time.

## Interface
- ADDR_W, 32: word-address width.
- DATA_W, 32: data word width.
- LINES, 64: number of one-word lines; power of two, ≥2. IDX_W = log2(LINES), TAG_W = ADDR_W − IDX_W.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cache_en  in  1  1 = cached mode, 0 = bypass (every access goes to memory, no fill, no lookup).
- flush  in  1  invalidate all lines; sampled only in IDLE.
- req_valid  in  1  CU request valid.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- resp_valid  out  1  one-cycle response pulse; CU always accepts.
- resp_rdata  out  DATA_W  read data; 0 on write responses.
- mem_req_valid  out  1  memory request valid.
- mem_req_ready  in  1  memory accepts request.
- mem_req_we  out  1  memory write.
- mem_req_addr  out  ADDR_W  memory word address.
- mem_req_wdata  out  DATA_W  memory write data.
- mem_resp_valid  in  1  read data return (reads only; writes get no response).
- mem_resp_rdata  in  DATA_W  read data.
- hit_cnt  out  32  saturating read-hit count.
- miss_cnt  out  32  saturating read-miss count (bypassed reads excluded).

## Operation
- Index = req_addr[IDX_W-1:0]; tag = req_addr[ADDR_W-1:IDX_W]. Per line: valid bit, tag, data.
- States: IDLE, MREQ (drive memory request), MWAIT (await read data), RESP (emit response).
- IDLE: req_ready = ~flush. On flush: clear all valid bits; any concurrent req_valid is not accepted. On req_valid && req_ready: latch request, then:
  - cached read hit → RESP with line data; hit_cnt++.
  - cached read miss → MREQ; miss_cnt++.
  - bypass read → MREQ.
  - write (either mode) → MREQ. In cached mode, if tag matches a valid line, update that line's data in the same cycle. Otherwise the cache is unchanged (no allocate).
- MREQ: mem_req_valid = 1 with latched we/addr/wdata, held stable until mem_req_ready. On acceptance: read → MWAIT, write → RESP.
- MWAIT: on mem_resp_valid, capture data. In cached mode, fill the line (valid=1, tag, data); in bypass, do not fill. Then → RESP.
- RESP: resp_valid = 1 for exactly one cycle, resp_rdata = hit/fill/bypass data (0 for writes). Then → IDLE.
- Counters saturate at 32'hFFFF_FFFF; they are not cleared by flush.
- cache_en is sampled at request acceptance; changes mid-transaction do not affect that transaction.

## Timing
- Reset (rst=1 at clock edge), regardless of state: state=IDLE, all valid bits=0, hit_cnt=miss_cnt=0. All outputs 0 except req_ready, which is 1 after reset (IDLE, flush=0). Any in-flight memory transaction is abandoned; a late mem_resp_valid arriving in IDLE is ignored.
- Read hit: accept at cycle N, resp_valid at N+1 (data read from registered arrays); req_ready low at N+1, high at N+2. Maximum throughput is one hit every 2 cycles.
- Read miss: accept N; mem_req_valid from N+1. If mem_req_ready at N+1 and mem_resp_valid at N+k (k≥2), resp_valid at N+k+1.
- Write: accept N; mem_req_valid from N+1; with mem_req_ready at N+1, resp_valid at N+2.
- req_ready = 0 in every state except IDLE. mem_req_valid is never deasserted before mem_req_ready.
- Flush takes effect at the edge it is sampled; a read to any address in the next accepted request misses.

## Test plan
- Reset then read 0x0000_0040 (cached), memory returns 0xDEAD_BEEF after 3 cycles → miss, resp_rdata=0xDEAD_BEEF, miss_cnt=1. Repeat the read → resp_valid 1 cycle after accept with 0xDEAD_BEEF, no memory request, hit_cnt=1.
- Write 0x1234_5678 to 0x40 (line valid) → mem write issued with same addr/data, resp_valid with rdata=0. Subsequent read of 0x40 → hit returning 0x1234_5678.
- Write to 0x80 (invalid line, LINES=64) → mem write only. Read 0x80 → miss (no allocate).
- Conflict: fill 0x40, then read 0x80 (same index 0, different tag) → miss and refill. Read 0x40 → miss again.
- flush and req_valid asserted together in IDLE → req_ready=0, request not taken, all lines invalid. Next read of 0x40 → miss. Bypass (cache_en=0) read → memory access, no fill, counters unchanged.
- Hold mem_req_ready=0 for 5 cycles → mem_req fields stable throughout. Assert rst during MWAIT → outputs reset next cycle, late mem_resp_valid ignored, no resp_valid.
